// File: rtl/rdout_seq_if.sv
// Signal bundle between the read-control FIFOs and the readout sequencer.
// Names are from the sequencer's side: i_ flows into it, o_ is driven by it.
interface rdout_seq_if;
    logic [3:0]  i_state;
    logic        i_rdena;
    logic        i_tempty;
    logic [3:0]  i_blkout;
    logic        i_scnd_blk;
    logic [7:0]  i_l1pout;
    logic        i_lct_ph_out;
    logic [5:0]  i_l1anum;
    logic        i_l1a_phase_out;
    logic        i_dfull;

    logic        o_trgdone;
    logic        o_popl1an;
    logic [6:0]  o_sca_adr;
    logic        o_adc_conv;
    logic        o_smp_we;
    logic        o_hdr_we;
    logic [19:0] o_hdr_data;
    logic        o_busy;
    logic [11:0] o_evt_cnt;

    modport slave (
        input  i_state, i_rdena, i_tempty, i_blkout, i_scnd_blk, i_l1pout,
               i_lct_ph_out, i_l1anum, i_l1a_phase_out, i_dfull,
        output o_trgdone, o_popl1an, o_sca_adr, o_adc_conv, o_smp_we,
               o_hdr_we, o_hdr_data, o_busy, o_evt_cnt
    );

    modport master (
        output i_state, i_rdena, i_tempty, i_blkout, i_scnd_blk, i_l1pout,
               i_lct_ph_out, i_l1anum, i_l1a_phase_out, i_dfull,
        input  o_trgdone, o_popl1an, o_sca_adr, o_adc_conv, o_smp_we,
               o_hdr_we, o_hdr_data, o_busy, o_evt_cnt
    );
endinterface

// File: rtl/rdout_seq.sv
// Readout sequencer: walks the 8 SCA cells of each pending block, one cell per
// 16-clock STATE period, and writes one header per new event.
module rdout_seq #(
    parameter bit TMR = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    rdout_seq_if.slave bus
);
    localparam int NCOPY = TMR ? 3 : 1;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    logic [NCOPY-1:0]       r_state;
    logic [NCOPY-1:0][2:0]  r_cell;
    logic [NCOPY-1:0][11:0] r_evt_cnt;

    logic        w_state_bit;
    state_t      w_state;
    logic [2:0]  w_cell;
    logic [11:0] w_evt_cnt;

    // Every copy is loaded from the same voted next value, so a single upset is
    // out-voted and then scrubbed on the following edge.
    generate
        if (TMR) begin : g_vote
            assign w_state_bit = (r_state[0] & r_state[1]) | (r_state[0] & r_state[2]) |
                                 (r_state[1] & r_state[2]);
            assign w_cell      = (r_cell[0] & r_cell[1]) | (r_cell[0] & r_cell[2]) |
                                 (r_cell[1] & r_cell[2]);
            assign w_evt_cnt   = (r_evt_cnt[0] & r_evt_cnt[1]) | (r_evt_cnt[0] & r_evt_cnt[2]) |
                                 (r_evt_cnt[1] & r_evt_cnt[2]);
        end else begin : g_plain
            assign w_state_bit = r_state[0];
            assign w_cell      = r_cell[0];
            assign w_evt_cnt   = r_evt_cnt[0];
        end
    endgenerate

    assign w_state = state_t'(w_state_bit);

    state_t      w_state_next;
    logic [2:0]  w_cell_next;
    logic [11:0] w_evt_cnt_next;
    logic        w_start;
    logic        w_new_evt;
    logic        w_adc;
    logic        w_smp;
    logic        w_done;

    always_comb begin
        w_state_next   = w_state;
        w_cell_next    = w_cell;
        w_evt_cnt_next = w_evt_cnt;
        w_start        = 1'b0;
        w_new_evt      = 1'b0;
        w_adc          = 1'b0;
        w_smp          = 1'b0;
        w_done         = 1'b0;
        case (w_state)
            IDLE: begin
                // DFULL and RDENA only gate the start; a running block always finishes.
                if (bus.i_state == 4'd4 && !bus.i_tempty && bus.i_rdena && !bus.i_dfull) begin
                    w_start      = 1'b1;
                    w_new_evt    = !bus.i_scnd_blk;
                    w_state_next = READ;
                    w_cell_next  = 3'd0;
                    if (!bus.i_scnd_blk) begin
                        w_evt_cnt_next = w_evt_cnt + 12'd1;
                    end
                end
            end
            READ: begin
                w_adc = (bus.i_state == 4'd5);
                if (bus.i_state == 4'd15) begin
                    w_smp = 1'b1;
                    if (w_cell == 3'd7) begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                        w_cell_next  = 3'd0;
                    end else begin
                        w_cell_next = w_cell + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= '0;
            r_cell    <= '0;
            r_evt_cnt <= '0;
        end else begin
            r_state   <= {NCOPY{w_state_next == READ}};
            r_cell    <= {NCOPY{w_cell_next}};
            r_evt_cnt <= {NCOPY{w_evt_cnt_next}};
        end
    end

    logic [3:0]  r_blk;
    logic [6:0]  r_sca_adr;
    logic [19:0] r_hdr_data;
    logic        r_trgdone;
    logic        r_popl1an;
    logic        r_adc_conv;
    logic        r_smp_we;
    logic        r_hdr_we;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_blk      <= '0;
            r_sca_adr  <= '0;
            r_hdr_data <= '0;
            r_trgdone  <= 1'b0;
            r_popl1an  <= 1'b0;
            r_adc_conv <= 1'b0;
            r_smp_we   <= 1'b0;
            r_hdr_we   <= 1'b0;
        end else begin
            r_trgdone  <= w_done;
            r_popl1an  <= w_new_evt;
            r_hdr_we   <= w_new_evt;
            r_adc_conv <= w_adc;
            r_smp_we   <= w_smp;
            if (w_start) begin
                r_blk     <= bus.i_blkout;
                r_sca_adr <= {bus.i_blkout, 3'd0};
                if (w_new_evt) begin
                    r_hdr_data <= {bus.i_l1a_phase_out, bus.i_lct_ph_out, bus.i_l1anum,
                                   bus.i_l1pout, bus.i_blkout};
                end
            end else if (w_smp && !w_done) begin
                r_sca_adr <= {r_blk, w_cell_next};
            end
        end
    end

    assign bus.o_trgdone  = r_trgdone;
    assign bus.o_popl1an  = r_popl1an;
    assign bus.o_sca_adr  = r_sca_adr;
    assign bus.o_adc_conv = r_adc_conv;
    assign bus.o_smp_we   = r_smp_we;
    assign bus.o_hdr_we   = r_hdr_we;
    assign bus.o_hdr_data = r_hdr_data;
    assign bus.o_busy     = (w_state == READ);
    assign bus.o_evt_cnt  = w_evt_cnt;
endmodule
